// File: rtl/ssd1306_pkg.sv
// Shared types and the SSD1306 power-up command list used by the SPI byte sequencer.
package ssd1306_pkg;

   typedef enum logic [2:0] {
      RST_HOLD,
      RST_WAIT,
      IDLE,
      SEND,
      WAIT
   } seq_state_t;

   localparam int INIT_LEN = 25;

   // Display off, clocking, multiplex, charge pump, addressing, remap, contrast, precharge, display on.
   localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
      8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
      8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

endpackage

// File: rtl/ssd1306_init_rom.sv
// Combinational lookup of the power-up command list; out-of-range indices read as zero.
module ssd1306_init_rom
   import ssd1306_pkg::*;
#(
   parameter int IDX_W = $clog2(INIT_LEN)
) (
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       cmd_byte
);

   always_comb begin
      cmd_byte = 8'h00;
      if (int'(idx) < INIT_LEN) begin
         cmd_byte = INIT_CMDS[idx];
      end
   end

endmodule

// File: rtl/ssd1306_spi_sequencer.sv
// Drives every byte to the SSD1306 through the shared shift register: panel reset, init list,
// then command/pixel arbitration with command priority, plus DC and CS framing per byte.
module ssd1306_spi_sequencer
   import ssd1306_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int RESET_CYCLES = 16
) (
   input  logic             clk_in,
   input  logic             reset_n_in,
   input  logic             cmd_valid_in,
   input  logic [WIDTH-1:0] cmd_data_in,
   output logic             cmd_ready_out,
   input  logic             pix_valid_in,
   input  logic [WIDTH-1:0] pix_data_in,
   output logic             pix_ready_out,
   output logic             init_done_out,
   output logic             sr_reset_out,
   output logic             sr_start_out,
   output logic [WIDTH-1:0] sr_data_out,
   input  logic             sr_ready_in,
   output logic             dc_out,
   output logic             cs_n_out,
   output logic             res_n_out
);

   localparam int CNT_W = $clog2(RESET_CYCLES + 1);
   localparam int IDX_W = $clog2(INIT_LEN);

   seq_state_t       state;
   logic [CNT_W-1:0] rst_cnt;
   logic [IDX_W-1:0] init_idx;
   logic             wait_armed;
   logic [7:0]       rom_byte;

   ssd1306_init_rom #(
      .IDX_W (IDX_W)
   ) u_init_rom (
      .idx      (init_idx),
      .cmd_byte (rom_byte)
   );

   assign sr_reset_out  = !reset_n_in;
   assign cmd_ready_out = (state == IDLE) && init_done_out;
   assign pix_ready_out = (state == IDLE) && init_done_out && !cmd_valid_in;

   // sr_data_out and dc_out double as the latched byte/DC registers, so they hold between bytes.
   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         state         <= RST_HOLD;
         rst_cnt       <= '0;
         init_idx      <= '0;
         wait_armed    <= 1'b0;
         init_done_out <= 1'b0;
         sr_start_out  <= 1'b0;
         sr_data_out   <= '0;
         dc_out        <= 1'b0;
         cs_n_out      <= 1'b1;
         res_n_out     <= 1'b0;
      end else begin
         unique case (state)
            RST_HOLD: begin
               if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) begin
                  rst_cnt   <= '0;
                  res_n_out <= 1'b1;
                  state     <= RST_WAIT;
               end else begin
                  rst_cnt <= rst_cnt + CNT_W'(1);
               end
            end
            RST_WAIT: begin
               if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) begin
                  rst_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  rst_cnt <= rst_cnt + CNT_W'(1);
               end
            end
            IDLE: begin
               if (!init_done_out) begin
                  sr_data_out  <= WIDTH'(rom_byte);
                  dc_out       <= 1'b0;
                  sr_start_out <= 1'b1;
                  cs_n_out     <= 1'b0;
                  state        <= SEND;
               end else if (cmd_valid_in) begin
                  sr_data_out  <= cmd_data_in;
                  dc_out       <= 1'b0;
                  sr_start_out <= 1'b1;
                  cs_n_out     <= 1'b0;
                  state        <= SEND;
               end else if (pix_valid_in) begin
                  sr_data_out  <= pix_data_in;
                  dc_out       <= 1'b1;
                  sr_start_out <= 1'b1;
                  cs_n_out     <= 1'b0;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (sr_ready_in) begin
                  sr_start_out <= 1'b0;
                  wait_armed   <= 1'b0;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               // Ready only falls one cycle after start, so the first WAIT cycle cannot trust it.
               wait_armed <= 1'b1;
               if (wait_armed && sr_ready_in) begin
                  cs_n_out <= 1'b1;
                  state    <= IDLE;
                  if (!init_done_out) begin
                     init_idx <= init_idx + IDX_W'(1);
                     if (init_idx == IDX_W'(INIT_LEN - 1)) begin
                        init_done_out <= 1'b1;
                     end
                  end
               end
            end
            default: state <= RST_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_ssd1306_spi_sequencer.sv
// Directed bench: behavioural shift register with a stall override, byte log, and hand-computed expectations.
module tb_ssd1306_spi_sequencer;

   localparam int WIDTH = 8;
   localparam int NINIT = 25;

   logic             clk_in = 1'b0;
   logic             reset_n_in;
   logic             cmd_valid_in;
   logic [WIDTH-1:0] cmd_data_in;
   logic             cmd_ready_out;
   logic             pix_valid_in;
   logic [WIDTH-1:0] pix_data_in;
   logic             pix_ready_out;
   logic             init_done_out;
   logic             sr_reset_out;
   logic             sr_start_out;
   logic [WIDTH-1:0] sr_data_out;
   logic             sr_ready_in;
   logic             dc_out;
   logic             cs_n_out;
   logic             res_n_out;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic       model_ready = 1'b1;
   int         model_cnt = 0;
   logic       stall = 1'b0;
   logic [7:0] log_data [128];
   logic       log_dc   [128];
   int         log_n = 0;

   logic [7:0] exp_init [NINIT] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
      8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
      8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

   ssd1306_spi_sequencer #(
      .WIDTH        (WIDTH),
      .RESET_CYCLES (16)
   ) dut (
      .clk_in        (clk_in),
      .reset_n_in    (reset_n_in),
      .cmd_valid_in  (cmd_valid_in),
      .cmd_data_in   (cmd_data_in),
      .cmd_ready_out (cmd_ready_out),
      .pix_valid_in  (pix_valid_in),
      .pix_data_in   (pix_data_in),
      .pix_ready_out (pix_ready_out),
      .init_done_out (init_done_out),
      .sr_reset_out  (sr_reset_out),
      .sr_start_out  (sr_start_out),
      .sr_data_out   (sr_data_out),
      .sr_ready_in   (sr_ready_in),
      .dc_out        (dc_out),
      .cs_n_out      (cs_n_out),
      .res_n_out     (res_n_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   assign sr_ready_in = model_ready && !stall;

   // Shift register model: ready low for WIDTH cycles starting the cycle after start is seen.
   always @(posedge clk_in) begin
      if (sr_reset_out) begin
         model_ready <= 1'b1;
         model_cnt   <= 0;
      end else if (model_ready && !stall && sr_start_out) begin
         model_ready       <= 1'b0;
         model_cnt         <= WIDTH - 1;
         log_data[log_n]   <= sr_data_out;
         log_dc[log_n]     <= dc_out;
         log_n             <= log_n + 1;
      end else if (!model_ready) begin
         if (model_cnt == 0) model_ready <= 1'b1;
         else                model_cnt   <= model_cnt - 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic cv, input logic [7:0] cd, input logic pv, input logic [7:0] pd);
      cmd_valid_in = cv;
      cmd_data_in  = cd;
      pix_valid_in = pv;
      pix_data_in  = pd;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_res_n"},     32'(res_n_out),     32'd0);
      checkOutput({tag, "_cs_n"},      32'(cs_n_out),      32'd1);
      checkOutput({tag, "_dc"},        32'(dc_out),        32'd0);
      checkOutput({tag, "_start"},     32'(sr_start_out),  32'd0);
      checkOutput({tag, "_data"},      32'(sr_data_out),   32'd0);
      checkOutput({tag, "_readies"},   32'({cmd_ready_out, pix_ready_out}), 32'd0);
      checkOutput({tag, "_init_done"}, 32'(init_done_out), 32'd0);
      checkOutput({tag, "_sr_reset"},  32'(sr_reset_out),  32'd1);
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (!cmd_ready_out && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      checkOutput({tag, "_reach_idle"}, 32'(cmd_ready_out), 32'd1);
   endtask

   // Releases reset from a negedge and follows the whole panel reset plus init list.
   task automatic runInit(input string tag);
      int n;
      int base;
      int early_ready;
      logic prev_cs;
      base = log_n;
      reset_n_in = 1'b1;
      n = 0;
      while (res_n_out === 1'b0 && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      checkOutput({tag, "_res_low_cycles"}, 32'(n), 32'd16);
      n = 0;
      while (sr_start_out !== 1'b1 && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      checkOutput({tag, "_res_high_to_start"}, 32'(n), 32'd17);
      checkOutput({tag, "_res_n_held"}, 32'(res_n_out), 32'd1);
      checkOutput({tag, "_first_byte"}, 32'(sr_data_out), 32'h00AE);
      checkOutput({tag, "_first_dc"},   32'(dc_out),      32'd0);
      checkOutput({tag, "_first_cs_n"}, 32'(cs_n_out),    32'd0);
      n = 0;
      early_ready = 0;
      prev_cs = cs_n_out;
      while (init_done_out !== 1'b1 && n < 1000) begin
         if (cmd_ready_out || pix_ready_out) early_ready++;
         prev_cs = cs_n_out;
         @(negedge clk_in);
         n++;
      end
      checkOutput({tag, "_init_done"},     32'(init_done_out), 32'd1);
      checkOutput({tag, "_early_ready"},   32'(early_ready),   32'd0);
      checkOutput({tag, "_done_from_wait"}, 32'(prev_cs),      32'd0);
      checkOutput({tag, "_done_cs_n"},     32'(cs_n_out),      32'd1);
      checkOutput({tag, "_init_count"},    32'(log_n - base),  32'(NINIT));
      for (int i = 0; i < NINIT; i++) begin
         checkOutput($sformatf("%s_init_byte%0d", tag, i), 32'({log_dc[base+i], log_data[base+i]}),
                     32'({1'b0, exp_init[i]}));
      end
   endtask

   initial begin
      int n;
      int k;
      int hi;
      int lo;
      int bad_cs;
      int bad_rdy;
      int base;
      int acc [3];

      reset_n_in = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      repeat (3) @(negedge clk_in);
      checkResetValues("por");
      runInit("init1");

      // Command and pixel offered together: command wins, pixel follows one byte later.
      base = log_n;
      applyStimulus(1'b1, 8'h81, 1'b1, 8'h55);
      #1;
      checkOutput("tie_cmd_ready", 32'(cmd_ready_out), 32'd1);
      checkOutput("tie_pix_ready", 32'(pix_ready_out), 32'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h55);
      n = 0;
      while (!pix_ready_out && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      checkOutput("tie_pix_wait", 32'(n), 32'd10);
      @(posedge clk_in);
      @(negedge clk_in);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      waitIdle("tie");
      checkOutput("tie_first",  32'({log_dc[base],   log_data[base]}),   32'h0081);
      checkOutput("tie_second", 32'({log_dc[base+1], log_data[base+1]}), 32'h0155);

      // Continuous pixel stream: one accept every WIDTH+3 cycles.
      base = log_n;
      applyStimulus(1'b0, 8'h00, 1'b1, 8'hA5);
      #1;
      k = 0;
      hi = 0;
      lo = 0;
      n = 0;
      while (k < 3 && n < 100) begin
         if (k == 1) begin
            if (cs_n_out) hi++;
            else          lo++;
         end
         if (pix_ready_out) begin
            acc[k] = cyc;
            k++;
         end
         if (k < 3) begin
            @(negedge clk_in);
            n++;
         end
      end
      checkOutput("stream_accepts", 32'(k), 32'd3);
      checkOutput("stream_gap1", 32'(acc[1] - acc[0]), 32'd11);
      checkOutput("stream_gap2", 32'(acc[2] - acc[1]), 32'd11);
      checkOutput("stream_cs_high", 32'(hi), 32'd1);
      checkOutput("stream_cs_low",  32'(lo), 32'd10);
      @(posedge clk_in);
      @(negedge clk_in);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      waitIdle("stream");
      checkOutput("stream_count", 32'(log_n - base), 32'd3);
      checkOutput("stream_byte",  32'({log_dc[base+2], log_data[base+2]}), 32'h01A5);

      // Shift register stuck busy: WAIT must hold with CS low and nothing accepted.
      base = log_n;
      applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
      @(posedge clk_in);
      @(negedge clk_in);
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h77);
      @(negedge clk_in);
      stall = 1'b1;
      bad_cs = 0;
      bad_rdy = 0;
      repeat (30) begin
         @(negedge clk_in);
         if (cs_n_out !== 1'b0) bad_cs++;
         if (cmd_ready_out || pix_ready_out) bad_rdy++;
      end
      checkOutput("stall_cs_n",  32'(bad_cs),  32'd0);
      checkOutput("stall_ready", 32'(bad_rdy), 32'd0);
      checkOutput("stall_count", 32'(log_n - base), 32'd1);
      checkOutput("stall_start", 32'(sr_start_out), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      stall = 1'b0;
      waitIdle("stall");
      checkOutput("stall_byte", 32'({log_dc[base], log_data[base]}), 32'h003C);

      // Reset in the middle of a byte: everything returns to reset values and init restarts.
      applyStimulus(1'b1, 8'h10, 1'b0, 8'h00);
      @(posedge clk_in);
      @(negedge clk_in);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      @(negedge clk_in);
      @(negedge clk_in);
      checkOutput("midwait_cs_n", 32'(cs_n_out), 32'd0);
      reset_n_in = 1'b0;
      #1;
      checkOutput("midwait_sr_reset", 32'(sr_reset_out), 32'd1);
      @(posedge clk_in);
      @(negedge clk_in);
      checkResetValues("midwait");
      runInit("init2");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
